gpio_irq_detector: RTL and testbench

Parametrised GPIO input conditioner and interrupt source for the APB GPIO block. Each of WIDTH pins is synchronised, glitch-filtered by a programmable cycle count, and edge-detected. A per-pin edge mode selects which edges latch a sticky pending bit, and enabled pending bits are OR-reduced onto a single interrupt line. The block sits between the pad inputs and the GPIO register file, which supplies configuration and write-1-to-clear pulses.

---
 rtl/gpio_irq_pkg.sv | 25 ++
 rtl/gpio_irq_channel.sv | 75 +++++++
 rtl/gpio_irq_detector.sv | 45 ++++
 tb/tb_gpio_irq_detector.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared types for the GPIO interrupt detector: edge-mode encoding and the
// helper that decides whether a filtered edge should latch a pending bit.
package gpio_irq_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    function automatic logic edge_matches(input edge_mode_t mode,
                                          input logic       rise,
                                          input logic       fall);
        logic hit;
        unique case (mode)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_irq_channel.sv
// One GPIO pin: synchroniser chain, glitch filter, registered edge pulses
// and the sticky pending flag.
module gpio_irq_channel
    import gpio_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                sig_i,
    input  edge_mode_t          mode_i,
    input  logic [FILTER_W-1:0] filter_len_i,
    input  logic                clear_i,
    output logic                filtered_o,
    output logic                pos_edge_o,
    output logic                neg_edge_o,
    output logic                pending_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILTER_W-1:0]    count_q, count_d;
    logic                   filt_q, filt_d;
    logic                   pos_q, neg_q;
    logic                   pend_q, pend_d;
    logic                   s;
    logic                   rise, fall;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_i};
        count_d = '0;
        filt_d  = filt_q;
        rise    = 1'b0;
        fall    = 1'b0;
        // Counter only runs while the synchronised level disagrees with the
        // filtered one, and is compared before incrementing so it cannot wrap.
        if (s != filt_q) begin
            if (count_q >= filter_len_i) begin
                filt_d = s;
                rise   = s;
                fall   = ~s;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
        // A new matching event overrides a clear in the same cycle.
        pend_d = edge_matches(mode_i, rise, fall) | (pend_q & ~clear_i);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q  <= '0;
            count_q <= '0;
            filt_q  <= 1'b0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            count_q <= count_d;
            filt_q  <= filt_d;
            pos_q   <= rise;
            neg_q   <= fall;
            pend_q  <= pend_d;
        end
    end

    assign filtered_o = filt_q;
    assign pos_edge_o = pos_q;
    assign neg_edge_o = neg_q;
    assign pending_o  = pend_q;

endmodule

// File: rtl/gpio_irq_detector.sv
// GPIO interrupt source: WIDTH independent conditioned channels whose enabled
// pending flags are OR-reduced onto a single interrupt line.
module gpio_irq_detector
    import gpio_irq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [WIDTH-1:0]     signal_in,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [FILTER_W-1:0]  filter_len,
    input  logic [WIDTH-1:0]     irq_en,
    input  logic [WIDTH-1:0]     clear,
    output logic [WIDTH-1:0]     filtered,
    output logic [WIDTH-1:0]     pos_edge,
    output logic [WIDTH-1:0]     neg_edge,
    output logic [WIDTH-1:0]     pending,
    output logic                 irq
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        gpio_irq_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_W    (FILTER_W)
        ) u_ch (
            .clk          (clk),
            .n_rst        (n_rst),
            .sig_i        (signal_in[i]),
            .mode_i       (edge_mode_t'(mode[2*i +: 2])),
            .filter_len_i (filter_len),
            .clear_i      (clear[i]),
            .filtered_o   (filtered[i]),
            .pos_edge_o   (pos_edge[i]),
            .neg_edge_o   (neg_edge[i]),
            .pending_o    (pending[i])
        );
    end

    // Enable masks only the interrupt line; pending stays visible to software.
    assign irq = |(pending & irq_en);

endmodule

// File: tb/tb_gpio_irq_detector.sv
// Self-checking bench for gpio_irq_detector: per-cycle expectation records
// pushed to a scoreboard queue and compared after each clock edge.
module tb_gpio_irq_detector;

    typedef struct {
        logic [7:0]  sig;
        logic [15:0] mode;
        logic [3:0]  flen;
        logic [7:0]  en;
        logic [7:0]  clr;
        logic [7:0]  filt;
        logic [7:0]  pos;
        logic [7:0]  neg;
        logic [7:0]  pend;
        logic        irq;
    } vec_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  signal_in;
    logic [15:0] mode;
    logic [3:0]  filter_len;
    logic [7:0]  irq_en;
    logic [7:0]  clear;
    logic [7:0]  filtered, pos_edge, neg_edge, pending;
    logic        irq;

    int   errors = 0;
    int   checks = 0;
    vec_t sb_q[$];
    vec_t tbl[10];

    gpio_irq_detector #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .FILTER_W    (4)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .signal_in  (signal_in),
        .mode       (mode),
        .filter_len (filter_len),
        .irq_en     (irq_en),
        .clear      (clear),
        .filtered   (filtered),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .pending    (pending),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] sig, input logic [15:0] md,
                                input logic [3:0] fl, input logic [7:0] en,
                                input logic [7:0] clr, input logic [7:0] filt,
                                input logic [7:0] pos, input logic [7:0] neg,
                                input logic [7:0] pend, input logic ir);
        vec_t v;
        v.sig = sig; v.mode = md; v.flen = fl; v.en = en; v.clr = clr;
        v.filt = filt; v.pos = pos; v.neg = neg; v.pend = pend; v.irq = ir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (check %0d): got %h, expected %h", name, checks, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        signal_in  = v.sig;
        mode       = v.mode;
        filter_len = v.flen;
        irq_en     = v.en;
        clear      = v.clr;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".filtered"}, filtered, e.filt);
        chk({tag, ".pos_edge"}, pos_edge, e.pos);
        chk({tag, ".neg_edge"}, neg_edge, e.neg);
        chk({tag, ".pending"},  pending,  e.pend);
        chk({tag, ".irq"},      {7'd0, irq}, {7'd0, e.irq});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".filtered"}, filtered, 8'h00);
        chk({tag, ".pos_edge"}, pos_edge, 8'h00);
        chk({tag, ".neg_edge"}, neg_edge, 8'h00);
        chk({tag, ".pending"},  pending,  8'h00);
        chk({tag, ".irq"},      {7'd0, irq}, 8'h00);
    endtask

    initial begin
        n_rst = 1'b0; signal_in = '0; mode = '0; filter_len = '0; irq_en = '0; clear = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) step(mk(8'h00, 16'h0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0), "idle");

        // Pass-through with filter_len=0, RISE on ch0; then fall and clear.
        tbl[0] = mk(8'h01, 16'h0001, 4'd0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tbl[1] = mk(8'h01, 16'h0001, 4'd0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tbl[2] = mk(8'h01, 16'h0001, 4'd0, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1);
        tbl[3] = mk(8'h01, 16'h0001, 4'd0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);
        tbl[4] = mk(8'h00, 16'h0001, 4'd0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);
        tbl[5] = mk(8'h00, 16'h0001, 4'd0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);
        tbl[6] = mk(8'h00, 16'h0001, 4'd0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 1'b1);
        tbl[7] = mk(8'h00, 16'h0001, 4'd0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
        tbl[8] = mk(8'h00, 16'h0001, 4'd0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tbl[9] = mk(8'h00, 16'h0001, 4'd0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("pass[%0d]", i));

        // filter_len=3: a 3-cycle glitch is rejected, a 4-cycle pulse passes at edge 5.
        for (int e = 0; e < 10; e++)
            step(mk((e < 3) ? 8'h01 : 8'h00, 16'h0001, 4'd3, 8'h01, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 1'b0), $sformatf("glitch[%0d]", e));
        for (int e = 0; e < 13; e++)
            step(mk((e < 4) ? 8'h01 : 8'h00, 16'h0001, 4'd3, 8'h01, 8'h00,
                    (e >= 5 && e < 9) ? 8'h01 : 8'h00, (e == 5) ? 8'h01 : 8'h00,
                    (e == 9) ? 8'h01 : 8'h00, (e >= 5) ? 8'h01 : 8'h00, e >= 5),
                 $sformatf("pulse4[%0d]", e));
        step(mk(8'h00, 16'h0001, 4'd3, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0), "pulse4.clr");

        // BOTH mode: set on rise, clear, set on fall, then set beats a held clear.
        for (int e = 0; e < 10; e++)
            step(mk(8'h01, 16'h0003, 4'd0, 8'h01, 8'h00, (e >= 2) ? 8'h01 : 8'h00,
                    (e == 2) ? 8'h01 : 8'h00, 8'h00, (e >= 2) ? 8'h01 : 8'h00, e >= 2),
                 $sformatf("both_rise[%0d]", e));
        step(mk(8'h01, 16'h0003, 4'd0, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0), "both.clr");
        for (int e = 0; e < 10; e++)
            step(mk(8'h00, 16'h0003, 4'd0, 8'h01, 8'h00, (e < 2) ? 8'h01 : 8'h00, 8'h00,
                    (e == 2) ? 8'h01 : 8'h00, (e >= 2) ? 8'h01 : 8'h00, e >= 2),
                 $sformatf("both_fall[%0d]", e));
        for (int e = 0; e < 5; e++)
            step(mk(8'h01, 16'h0003, 4'd0, 8'h01, 8'h01, (e >= 2) ? 8'h01 : 8'h00,
                    (e == 2) ? 8'h01 : 8'h00, 8'h00, (e == 2) ? 8'h01 : 8'h00, e == 2),
                 $sformatf("set_wins[%0d]", e));

        // OFF mode still produces pulses but never pending.
        for (int e = 0; e < 5; e++)
            step(mk(8'h00, 16'h0000, 4'd0, 8'h01, 8'h00, (e < 2) ? 8'h01 : 8'h00, 8'h00,
                    (e == 2) ? 8'h01 : 8'h00, 8'h00, 1'b0), $sformatf("off_fall[%0d]", e));
        for (int e = 0; e < 5; e++)
            step(mk(8'h01, 16'h0000, 4'd0, 8'h01, 8'h00, (e >= 2) ? 8'h01 : 8'h00,
                    (e == 2) ? 8'h01 : 8'h00, 8'h00, 8'h00, 1'b0), $sformatf("off_rise[%0d]", e));
        // FALL with irq masked: pending sets, irq stays low until enabled.
        for (int e = 0; e < 5; e++)
            step(mk(8'h00, 16'h0002, 4'd0, 8'h00, 8'h00, (e < 2) ? 8'h01 : 8'h00, 8'h00,
                    (e == 2) ? 8'h01 : 8'h00, (e >= 2) ? 8'h01 : 8'h00, 1'b0),
                 $sformatf("mask[%0d]", e));
        irq_en = 8'h01;
        #1;
        chk("unmask.irq_comb", {7'd0, irq}, 8'h01);
        step(mk(8'h00, 16'h0002, 4'd0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1), "unmask");

        // Reset with a partial count of 2 while the pin is high.
        for (int e = 0; e < 4; e++)
            step(mk(8'h01, 16'h0001, 4'd3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1),
                 $sformatf("pre_rst[%0d]", e));
        n_rst = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("held_rst");
        n_rst = 1'b1;
        for (int e = 0; e < 8; e++)
            step(mk(8'h01, 16'h0001, 4'd3, 8'h01, 8'h00, (e >= 5) ? 8'h01 : 8'h00,
                    (e == 5) ? 8'h01 : 8'h00, 8'h00, (e >= 5) ? 8'h01 : 8'h00, e >= 5),
                 $sformatf("post_rst[%0d]", e));

        // Independence: ch0 rises (RISE) while ch7 falls (FALL) in the same cycle.
        for (int e = 0; e < 4; e++)
            step(mk(8'h80, 16'h0000, 4'd0, 8'h00, 8'h00, (e < 2) ? 8'h01 : 8'h80,
                    (e == 2) ? 8'h80 : 8'h00, (e == 2) ? 8'h01 : 8'h00, 8'h01, 1'b0),
                 $sformatf("prep7[%0d]", e));
        step(mk(8'h80, 16'h0000, 4'd0, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0), "prep7.clr");
        for (int e = 0; e < 4; e++)
            step(mk(8'h01, 16'h8001, 4'd0, 8'h00, 8'h00, (e < 2) ? 8'h80 : 8'h01,
                    (e == 2) ? 8'h01 : 8'h00, (e == 2) ? 8'h80 : 8'h00,
                    (e >= 2) ? 8'h81 : 8'h00, 1'b0), $sformatf("indep[%0d]", e));
        step(mk(8'h01, 16'h8001, 4'd0, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h81, 1'b1), "indep.en");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
